// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: opcodes, table geometry,
// PHT counter encodings and the saturating-counter update rule.
package branch_predictor_pkg;

    // Control-flow opcodes the pipeline feeds into the predictor
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int BTB_IDX_BITS = 5;
    localparam int GHR_BITS     = 5;
    localparam int BTB_ENTRIES  = 1 << BTB_IDX_BITS;
    localparam int PHT_ENTRIES  = 1 << GHR_BITS;
    // Index covers pc[6:2]; the tag is everything above it
    localparam int TAG_BITS     = 32 - BTB_IDX_BITS - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_state_t;

    localparam pht_state_t PHT_RESET = WNT;

    // Two-bit saturating counter step toward the resolved direction
    function automatic pht_state_t pht_next(input pht_state_t cur, input logic taken);
        pht_state_t nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between the pipeline (master) and the branch predictor (slave):
// IF-stage prediction, EX-stage resolution/redirect, and perf counters.
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_cond;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, correct_pc,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, correct_pc,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Branch target buffer: direct-mapped, one combinational read port and one
// synchronous write port. Only valid bits are reset; payload is don't-care
// until its valid bit is set.
module btb
    import branch_predictor_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BTB_IDX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0]     rd_tag,
    output logic                    rd_hit,
    output logic [31:0]             rd_target,
    output logic                    rd_is_jump,
    input  logic                    wr_en,
    input  logic [BTB_IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]     wr_tag,
    input  logic [31:0]             wr_target,
    input  logic                    wr_is_jump
);

    logic [BTB_ENTRIES-1:0] valid;
    logic [BTB_ENTRIES-1:0] jump_bits;
    logic [TAG_BITS-1:0]    tag_mem    [BTB_ENTRIES];
    logic [31:0]            target_mem [BTB_ENTRIES];

    // Valid bits: cleared asynchronously, set on every allocation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Entry payload: overwritten on allocation, conflicting entries replaced
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
            jump_bits[wr_idx]  <= wr_is_jump;
        end
    end

    assign rd_hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_target  = target_mem[rd_idx];
    assign rd_is_jump = jump_bits[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Gshare-style branch predictor: BTB for targets, GHR-xor-PC indexed PHT of
// two-bit counters for conditional direction, plus perf counters.
module branch_predictor
    import branch_predictor_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bus
);

    pht_state_t                 pht [PHT_ENTRIES];
    logic [GHR_BITS-1:0]        ghr;
    logic [31:0]                branch_cnt;
    logic [31:0]                mispred_cnt;

    logic                       btb_hit;
    logic [31:0]                btb_target;
    logic                       btb_is_jump;
    logic [GHR_BITS-1:0]        rd_pht_idx;
    logic [GHR_BITS-1:0]        upd_pht_idx;
    logic                       mispredict;

    btb u_btb (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (bus.if_pc[6:2]),
        .rd_tag     (bus.if_pc[31:7]),
        .rd_hit     (btb_hit),
        .rd_target  (btb_target),
        .rd_is_jump (btb_is_jump),
        .wr_en      (bus.upd_valid && bus.upd_taken),
        .wr_idx     (bus.upd_pc[6:2]),
        .wr_tag     (bus.upd_pc[31:7]),
        .wr_target  (bus.upd_target),
        .wr_is_jump (!bus.upd_is_cond)
    );

    assign rd_pht_idx  = bus.if_pc[6:2] ^ ghr;
    assign upd_pht_idx = bus.upd_pc[6:2] ^ ghr;

    // IF prediction reads pre-update state; no bypass from the EX update
    assign bus.pred_taken  = btb_hit && (btb_is_jump || pht[rd_pht_idx][1]);
    assign bus.pred_target = btb_hit ? btb_target : bus.if_pc + 32'd4;

    // Redirect when direction differs, or a taken branch went somewhere else;
    // updates are ignored while reset is held, so no flush is raised then
    assign mispredict = reset && bus.upd_valid &&
                        ((bus.upd_taken != bus.upd_pred_taken) ||
                         (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
    assign bus.mispredict  = mispredict;
    assign bus.correct_pc  = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;
    assign bus.branch_cnt  = branch_cnt;
    assign bus.mispred_cnt = mispred_cnt;

    // Direction state: only conditional branches train the PHT and GHR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= PHT_RESET;
            end
            ghr <= '0;
        end else if (bus.upd_valid && bus.upd_is_cond) begin
            pht[upd_pht_idx] <= pht_next(pht[upd_pht_idx], bus.upd_taken);
            ghr              <= {ghr[GHR_BITS-2:0], bus.upd_taken};
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (bus.upd_valid && (branch_cnt != 32'hFFFF_FFFF)) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: prediction, redirect, BTB/PHT/GHR
// training, jump handling, wrap-around, and mid-update reset.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_if bus();

    branch_predictor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic cond,
                           input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        bus.upd_valid       = v;
        bus.upd_pc          = pc;
        bus.upd_is_cond     = cond;
        bus.upd_taken       = taken;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = ptaken;
        bus.upd_pred_target = ptgt;
    endtask

    task automatic idle();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        reset     = 1'b0;
        bus.if_pc = 32'h0000_0040;
        idle();
        #2;
        chk("rst_pred_taken", bus.pred_taken, 0);
        chk("rst_pred_target", bus.pred_target, 32'h44);
        chk("rst_branch_cnt", bus.branch_cnt, 0);
        chk("rst_mispred_cnt", bus.mispred_cnt, 0);
        tick();
        tick();
        reset = 1'b1;

        // First taken update: allocates BTB, PHT[16] -> WT, GHR=1
        set_upd(1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h44);
        #1;
        chk("u1_mispredict", bus.mispredict, 1);
        chk("u1_correct_pc", bus.correct_pc, 32'h80);
        tick();
        idle();
        bus.if_pc = 32'h40;
        #1;
        chk("u1_hit_target", bus.pred_target, 32'h80);
        chk("u1_pred_taken", bus.pred_taken, 0);
        chk("u1_branch_cnt", bus.branch_cnt, 1);
        chk("u1_mispred_cnt", bus.mispred_cnt, 1);

        // Second update still mispredicted in direction; GHR=3
        set_upd(1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h80);
        #1;
        chk("u2_mispredict", bus.mispredict, 1);
        tick();

        // Third update matches the carried prediction; GHR=7
        set_upd(1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        chk("u3_mispredict", bus.mispredict, 0);
        tick();
        idle();
        #1;
        chk("u3_branch_cnt", bus.branch_cnt, 3);
        chk("u3_mispred_cnt", bus.mispred_cnt, 2);
        chk("u3_pred_taken", bus.pred_taken, 0);

        // Three more correct takens: GHR saturates at 31, PHT[15] -> WT
        for (int i = 0; i < 3; i++) begin
            set_upd(1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
            tick();
        end
        idle();
        #1;
        chk("u6_pred_taken", bus.pred_taken, 1);
        chk("u6_branch_cnt", bus.branch_cnt, 6);
        chk("u6_mispred_cnt", bus.mispred_cnt, 2);
        chk("u6_ghr", dut.ghr, 5'd31);

        // Predicted taken to 0x80, resolves to 0x90; IF sees old target
        set_upd(1'b1, 32'h40, 1'b1, 1'b1, 32'h90, 1'b1, 32'h80);
        #1;
        chk("tgt_mispredict", bus.mispredict, 1);
        chk("tgt_correct_pc", bus.correct_pc, 32'h90);
        chk("tgt_no_bypass", bus.pred_target, 32'h80);
        tick();
        idle();
        #1;
        chk("tgt_new_target", bus.pred_target, 32'h90);
        chk("tgt_pred_taken", bus.pred_taken, 1);

        // Not-taken conditional: keeps BTB entry, GHR -> 30
        set_upd(1'b1, 32'h40, 1'b1, 1'b0, 32'h90, 1'b1, 32'h90);
        #1;
        chk("nt_mispredict", bus.mispredict, 1);
        chk("nt_correct_pc", bus.correct_pc, 32'h44);
        tick();
        idle();
        #1;
        chk("nt_keep_target", bus.pred_target, 32'h90);
        chk("nt_pred_taken", bus.pred_taken, 0);
        chk("nt_ghr", dut.ghr, 5'd30);
        chk("nt_mispred_cnt", bus.mispred_cnt, 4);

        // JAL: allocates jump entry, leaves GHR and PHT alone
        set_upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h104);
        #1;
        chk("jal_mispredict", bus.mispredict, 1);
        chk("jal_correct_pc", bus.correct_pc, 32'h200);
        tick();
        idle();
        bus.if_pc = 32'h100;
        #1;
        chk("jal_pred_taken", bus.pred_taken, 1);
        chk("jal_pred_target", bus.pred_target, 32'h200);
        chk("jal_ghr", dut.ghr, 5'd30);
        chk("jal_pht", dut.pht[30], 32'(WNT));
        chk("jal_branch_cnt", bus.branch_cnt, 9);

        // Wrap-around of pc+4 on both paths
        set_upd(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10);
        bus.if_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_mispredict", bus.mispredict, 1);
        chk("wrap_correct_pc", bus.correct_pc, 32'h0);
        chk("wrap_pred_target", bus.pred_target, 32'h0);
        tick();

        // upd_valid low suppresses mispredict and counting
        set_upd(1'b0, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        chk("novld_mispredict", bus.mispredict, 0);
        tick();
        chk("novld_branch_cnt", bus.branch_cnt, 10);
        chk("novld_mispred_cnt", bus.mispred_cnt, 6);

        // Reset lands between update setup and the clock edge
        set_upd(1'b1, 32'h300, 1'b1, 1'b1, 32'h400, 1'b0, 32'h304);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_branch_cnt", bus.branch_cnt, 0);
        chk("mid_rst_mispred_cnt", bus.mispred_cnt, 0);
        chk("mid_rst_ghr", dut.ghr, 0);
        tick();
        bus.if_pc = 32'h40;
        #1;
        chk("mid_rst_pred_taken", bus.pred_taken, 0);
        chk("mid_rst_pred_target", bus.pred_target, 32'h44);
        chk("mid_rst_cnt_held", bus.branch_cnt, 0);
        bus.if_pc = 32'h300;
        #1;
        chk("mid_rst_no_alloc", bus.pred_target, 32'h304);
        chk("mid_rst_pht", dut.pht[0], 32'(WNT));

        // First edge after release applies the pending update
        reset = 1'b1;
        tick();
        idle();
        #1;
        chk("post_rst_branch_cnt", bus.branch_cnt, 1);
        chk("post_rst_mispred_cnt", bus.mispred_cnt, 1);
        chk("post_rst_target", bus.pred_target, 32'h400);
        chk("post_rst_pred_taken", bus.pred_taken, 0);
        chk("post_rst_ghr", dut.ghr, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
